aes_cipher_core: RTL and testbench

- Iterative AES encryption datapath. Performs one cipher round per clock on a 128-bit block.
- Sits directly downstream of the key-expansion stage and consumes its flat expanded-key bus w (up to 15 round keys).
- Its output block feeds the SPI transmit path.
- Supports AES-128, AES-192 and AES-256, selected by Nr.

---
 rtl/aes_cipher_core.sv | 193 +++++++++++++++++++
 tb/tb_aes_cipher_core.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_core.sv
// Iterative AES-128/192/256 encryption core, one round per clock.
// Optional one-entry start queue under AES_START_QUEUE_EN.
module aes_cipher_core #(
  parameter int MAX_NR = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [3:0]                  Nr,
  input  logic [0:127]                data_in,
  input  logic [0:128*(MAX_NR+1)-1]   w,
  output logic                        busy,
  output logic                        done,
  output logic [0:127]                data_out
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {
    IDLE,
    ROUND
  } state_t;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes and ShiftRows fused: byte 4c+r reads column (c+r)%4
  function automatic logic [0:127] sub_shift(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[(4*c+r)*8 +: 8] = sb(s[(4*((c+r)%4)+r)*8 +: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] mix(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8 +: 8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  logic [0:127] rk [0:MAX_NR];

  for (genvar i = 0; i <= MAX_NR; i++) begin : g_rk
    assign rk[i] = w[i*128 +: 128];
  end

  state_t       st, st_nxt;
  logic [0:127] blk, blk_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [3:0]   nr_q, nr_nxt;
  logic [0:127] dout_nxt;
  logic         done_nxt;
  logic [0:127] sr;
  logic         valid_nr;
  logic         accept;

`ifdef AES_START_QUEUE_EN
  logic         pend_v, pend_v_nxt;
  logic [0:127] pend_d, pend_d_nxt;
  logic [3:0]   pend_nr, pend_nr_nxt;
`endif

  assign valid_nr = (Nr == 4'd10) || (Nr == 4'd12) || (Nr == 4'd14);
  assign accept   = start && valid_nr;
  assign sr       = sub_shift(blk);
  assign busy     = (st == ROUND);

  always_comb begin
    st_nxt   = st;
    blk_nxt  = blk;
    rnd_nxt  = rnd;
    nr_nxt   = nr_q;
    dout_nxt = data_out;
    done_nxt = 1'b0;
`ifdef AES_START_QUEUE_EN
    pend_v_nxt  = pend_v;
    pend_d_nxt  = pend_d;
    pend_nr_nxt = pend_nr;
`endif
    unique case (st)
      IDLE: begin
        if (accept) begin
          blk_nxt = data_in ^ rk[0];
          rnd_nxt = 4'd1;
          nr_nxt  = Nr;
          st_nxt  = ROUND;
        end
      end
      ROUND: begin
        if (rnd != nr_q) begin
          blk_nxt = mix(sr) ^ rk[rnd];
          rnd_nxt = rnd + 4'd1;
`ifdef AES_START_QUEUE_EN
          if (accept && !pend_v) begin
            pend_v_nxt  = 1'b1;
            pend_d_nxt  = data_in;
            pend_nr_nxt = Nr;
          end
`endif
        end else begin
          dout_nxt = sr ^ rk[nr_q];
          done_nxt = 1'b1;
          st_nxt   = IDLE;
`ifdef AES_START_QUEUE_EN
          // a start arriving in the final cycle is captured and used at once
          if (pend_v) begin
            blk_nxt    = pend_d ^ rk[0];
            rnd_nxt    = 4'd1;
            nr_nxt     = pend_nr;
            st_nxt     = ROUND;
            pend_v_nxt = 1'b0;
          end else if (accept) begin
            blk_nxt = data_in ^ rk[0];
            rnd_nxt = 4'd1;
            nr_nxt  = Nr;
            st_nxt  = ROUND;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      blk      <= '0;
      rnd      <= '0;
      nr_q     <= '0;
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      st       <= st_nxt;
      blk      <= blk_nxt;
      rnd      <= rnd_nxt;
      nr_q     <= nr_nxt;
      data_out <= dout_nxt;
      done     <= done_nxt;
    end
  end

`ifdef AES_START_QUEUE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v  <= 1'b0;
      pend_d  <= '0;
      pend_nr <= '0;
    end else begin
      pend_v  <= pend_v_nxt;
      pend_d  <= pend_d_nxt;
      pend_nr <= pend_nr_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_aes_cipher_core.sv
// Self-checking bench for aes_cipher_core: FIPS-197 vectors plus
// random blocks checked against an arithmetic AES model.
module tb_aes_cipher_core;

  localparam int MAX_NR = 14;
  localparam int WB = 128 * (MAX_NR + 1);

  logic            clk;
  logic            rst;
  logic            start;
  logic [3:0]      Nr;
  logic [0:127]    data_in;
  logic [0:WB-1]   w;
  logic            busy;
  logic            done;
  logic [0:127]    data_out;

  int vectors;
  int miscompares;

  logic [7:0] sbt [256];

  aes_cipher_core #(.MAX_NR(MAX_NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Nr       (Nr),
    .data_in  (data_in),
    .w        (w),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox;
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
        ^ rotl8(inv, 4) ^ 8'h63;
      sbt[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbt[v[31:24]], sbt[v[23:16]], sbt[v[15:8]], sbt[v[7:0]]};
  endfunction

  function automatic logic [0:WB-1] expand(input logic [0:255] key, input int nr);
    logic [31:0]   wd [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:WB-1] o;
    int            nk;
    int            tot;
    nk  = nr - 6;
    tot = 4 * (nr + 1);
    rc  = 8'h01;
    o   = '0;
    for (int i = 0; i < 60; i++) wd[i] = 32'h0;
    for (int i = 0; i < nk; i++) wd[i] = key[i*32 +: 32];
    for (int i = nk; i < tot; i++) begin
      t = wd[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      wd[i] = wd[i-nk] ^ t;
    end
    for (int i = 0; i < tot; i++) o[i*32 +: 32] = wd[i];
    return o;
  endfunction

  function automatic logic [0:127] cipher_ref(input logic [0:127] pt,
                                              input logic [0:WB-1] wk,
                                              input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [0:127] o;
    for (int b = 0; b < 16; b++) s[b] = pt[b*8 +: 8] ^ wk[b*8 +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          t[4*c+q] = sbt[s[4*((c+q)%4)+q]];
      if (r < nr) begin
        for (int c = 0; c < 4; c++)
          for (int q = 0; q < 4; q++)
            s[4*c+q] = gmul(8'h02, t[4*c+q]) ^ gmul(8'h03, t[4*c+(q+1)%4])
                     ^ t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4];
      end else begin
        for (int b = 0; b < 16; b++) s[b] = t[b];
      end
      for (int b = 0; b < 16; b++) s[b] = s[b] ^ wk[r*128 + b*8 +: 8];
    end
    for (int b = 0; b < 16; b++) o[b*8 +: 8] = s[b];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] nr, input logic [0:127] pt,
                        input logic [0:WB-1] wk, input logic [0:127] exp,
                        input string tag);
    int k;
    int bc;
    Nr = nr;
    data_in = pt;
    w = wk;
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 0;
    bc = 0;
    while (!done && k < 40) begin
      bc += int'(busy);
      tick;
      k++;
    end
    chk({tag, "_lat"}, 128'(k + 1), 128'(int'(nr) + 1));
    chk({tag, "_busy"}, 128'(bc), 128'(nr));
    chk({tag, "_data"}, data_out, exp);
    chk({tag, "_overlap"}, 128'(busy), 128'(0));
  endtask

  task automatic watch_quiet(input int n, input string tag);
    int d;
    int b;
    d = 0;
    b = 0;
    repeat (n) begin
      tick;
      d += int'(done);
      b += int'(busy);
    end
    chk({tag, "_done"}, 128'(d), 128'(0));
    chk({tag, "_busy"}, 128'(b), 128'(0));
  endtask

  localparam logic [0:127] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [0:WB-1]  w128;
    logic [0:WB-1]  w192;
    logic [0:WB-1]  w256;
    logic [0:WB-1]  wr;
    logic [0:255]   key;
    logic [0:127]   pt;
    logic [0:127]   pt2;
    logic [0:127]   prev;
    logic [3:0]     nr;
    int             k;
    int             gap;

    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    start = 1'b0;
    Nr = 4'd0;
    data_in = '0;
    w = '0;
    build_sbox;

    w128 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
    w192 = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                   64'h0}, 12);
    w256 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  14);

    repeat (2) tick;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_data", data_out, 128'h0);
    rst = 1'b0;
    tick;

    run_op(4'd10, PT, w128, C128, "aes128");
    tick;
    chk("done_pulse", 128'(done), 128'(0));
    run_op(4'd12, PT, w192, C192, "aes192");
    tick;
    run_op(4'd14, PT, w256, C256, "aes256");
    tick;

    prev = data_out;
    Nr = 4'd11;
    data_in = ~PT;
    start = 1'b1;
    tick;
    start = 1'b0;
    watch_quiet(20, "bad_nr");
    chk("bad_nr_data", data_out, prev);

    pt2 = {$urandom, $urandom, $urandom, $urandom};
    run_op(4'd10, PT, w128, C128, "b2b_a");
    run_op(4'd10, pt2, w128, cipher_ref(pt2, w128, 10), "b2b_b");
    tick;

`ifdef AES_START_QUEUE_EN
    Nr = 4'd10;
    data_in = PT;
    w = w128;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (2) tick;
    data_in = pt2;
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 3;
    while (!done && k < 40) begin
      tick;
      k++;
    end
    chk("q_first_lat", 128'(k), 128'(10));
    chk("q_first_data", data_out, C128);
    chk("q_first_busy", 128'(busy), 128'(1));
    tick;
    k = 1;
    gap = 0;
    while (!done && k < 40) begin
      gap += int'(!busy);
      tick;
      k++;
    end
    chk("q_second_gap", 128'(k), 128'(10));
    chk("q_busy_hole", 128'(gap), 128'(0));
    chk("q_second_data", data_out, cipher_ref(pt2, w128, 10));
    watch_quiet(25, "q_tail");
`else
    Nr = 4'd10;
    data_in = PT;
    w = w128;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (3) tick;
    data_in = pt2;
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 4;
    while (!done && k < 40) begin
      tick;
      k++;
    end
    chk("busy_start_lat", 128'(k), 128'(10));
    chk("busy_start_data", data_out, C128);
    watch_quiet(25, "busy_start_tail");
`endif

    Nr = 4'd10;
    data_in = PT;
    w = w128;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_done", 128'(done), 128'(0));
    chk("midrst_data", data_out, 128'h0);
    watch_quiet(20, "midrst_quiet");
    run_op(4'd10, PT, w128, C128, "post_rst");
    tick;

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 8; j++) key[j*32 +: 32] = $urandom;
      nr = 4'(10 + 2 * $urandom_range(0, 2));
      wr = expand(key, int'(nr));
      pt = {$urandom, $urandom, $urandom, $urandom};
      run_op(nr, pt, wr, cipher_ref(pt, wr, int'(nr)),
             $sformatf("rand%0d_nr%0d", i, nr));
    end
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
